// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared sequencer state, width defaults and saturation helpers
package dsp_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_ACC_W  = 72;

    typedef enum logic [1:0] {IDLE, RUN, WB, DONE} state_e;

    localparam logic signed [DEF_ACC_W-1:0] SAT_MAX =
        {{(DEF_ACC_W-DEF_DATA_W+1){1'b0}}, {(DEF_DATA_W-1){1'b1}}};
    localparam logic signed [DEF_ACC_W-1:0] SAT_MIN =
        {{(DEF_ACC_W-DEF_DATA_W+1){1'b1}}, {(DEF_DATA_W-1){1'b0}}};

    function automatic logic sat_ovf(input logic signed [DEF_ACC_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    function automatic logic [DEF_DATA_W-1:0] saturate(input logic signed [DEF_ACC_W-1:0] v);
        if (v > SAT_MAX) return {1'b0, {(DEF_DATA_W-1){1'b1}}};
        if (v < SAT_MIN) return {1'b1, {(DEF_DATA_W-1){1'b0}}};
        return v[DEF_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/regfile_mac_sequencer_if.sv
// rtl/regfile_mac_sequencer_if.sv - register file port bundle between sequencer and register file
interface regfile_mac_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;

    modport master (
        output ReadReg1, ReadReg2, RegWrite, WriteReg, WriteData,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  ReadReg1, ReadReg2, RegWrite, WriteReg, WriteData,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - signed multiply-accumulate with synchronous clear and enable
module mac_unit #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 72
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  acc_o
);
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0] acc_q, acc_d;

    assign prod = (2*DATA_W)'($signed(a_i)) * (2*DATA_W)'($signed(b_i));

    // the accumulator wraps modulo 2^ACC_W by design
    always_comb begin
        acc_d = acc_q;
        if (clr_i)     acc_d = '0;
        else if (en_i) acc_d = acc_q + ACC_W'(prod);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/regfile_mac_sequencer.sv
// rtl/regfile_mac_sequencer.sv - windowed dot-product job engine over the register file; MAC_SAT_EN adds saturating writeback and sat_flag
module regfile_mac_sequencer
    import dsp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int SHIFT  = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W:0]   len,
    input  logic [ADDR_W-1:0] dest_reg,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic              host_stall,
`ifdef MAC_SAT_EN
    output logic              sat_flag,
`endif
    input  logic              host_RegWrite,
    input  logic [ADDR_W-1:0] host_WriteReg,
    input  logic [DATA_W-1:0] host_WriteData,
    input  logic [ADDR_W-1:0] host_ReadReg1,
    input  logic [ADDR_W-1:0] host_ReadReg2,
    regfile_mac_sequencer_if.master rf
);
    localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d, len_q, len_d;
    logic [ADDR_W-1:0] base_a_q, base_a_d, base_b_q, base_b_d, dest_q, dest_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0] acc_shr;
    logic [DATA_W-1:0] wb_data;
    logic              mac_clr, mac_en;

    mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clock (clock),
        .reset (reset),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (rf.ReadData1),
        .b_i   (rf.ReadData2),
        .acc_o (acc)
    );

    assign acc_shr = $signed(acc) >>> SHIFT;

`ifdef MAC_SAT_EN
    logic sat_q, sat_d;
    assign wb_data  = saturate(acc_shr);
    assign sat_flag = sat_q;

    always_comb begin
        sat_d = sat_q;
        if (state_q == IDLE && start)                sat_d = 1'b0;
        else if (state_q == WB && sat_ovf(acc_shr))  sat_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) sat_q <= 1'b0;
        else       sat_q <= sat_d;
    end
`else
    assign wb_data = DATA_W'(acc_shr);
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        base_a_d     = base_a_q;
        base_b_d     = base_b_q;
        dest_d       = dest_q;
        result_d     = result_q;
        mac_clr      = 1'b0;
        mac_en       = 1'b0;
        rf.ReadReg1  = host_ReadReg1;
        rf.ReadReg2  = host_ReadReg2;
        rf.RegWrite  = host_RegWrite;
        rf.WriteReg  = host_WriteReg;
        rf.WriteData = host_WriteData;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_a_d = base_a;
                    base_b_d = base_b;
                    len_d    = len;
                    dest_d   = dest_reg;
                    idx_d    = '0;
                    mac_clr  = 1'b1;
                    if (len == '0) begin
                        result_d = '0;
                        state_d  = DONE;
                    end else begin
                        state_d  = RUN;
                    end
                end
            end
            RUN, WB: begin
                // the sequencer owns every port; host writes are dropped, not queued
                rf.ReadReg1  = base_a_q + idx_q[ADDR_W-1:0];
                rf.ReadReg2  = base_b_q + idx_q[ADDR_W-1:0];
                rf.RegWrite  = (state_q == WB);
                rf.WriteReg  = dest_q;
                rf.WriteData = wb_data;
                if (state_q == RUN) begin
                    mac_en = 1'b1;
                    idx_d  = idx_q + IDX_ONE;
                    if (idx_q + IDX_ONE == len_q) state_d = WB;
                end else begin
                    result_d = acc;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            dest_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            dest_q   <= dest_d;
            result_q <= result_d;
        end
    end

    assign busy       = (state_q == RUN) || (state_q == WB);
    assign done       = (state_q == DONE);
    assign result     = result_q;
    assign host_stall = busy && host_RegWrite;
endmodule

// File: tb/tb_regfile_mac_sequencer.sv
// tb/tb_regfile_mac_sequencer.sv - scoreboard bench for regfile_mac_sequencer with a behavioural register file
module tb_regfile_mac_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  base_a = '0, base_b = '0, dest_reg = '0;
    logic [5:0]  len = '0;
    logic        busy, done, host_stall;
    logic [71:0] result;
`ifdef MAC_SAT_EN
    logic        sat_flag;
`endif
    logic        host_RegWrite = 1'b0;
    logic [4:0]  host_WriteReg = '0, host_ReadReg1 = '0, host_ReadReg2 = '0;
    logic [31:0] host_WriteData = '0;

    regfile_mac_sequencer_if #(.DATA_W(32), .ADDR_W(5)) rf ();

    regfile_mac_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .base_a         (base_a),
        .base_b         (base_b),
        .len            (len),
        .dest_reg       (dest_reg),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .host_stall     (host_stall),
`ifdef MAC_SAT_EN
        .sat_flag       (sat_flag),
`endif
        .host_RegWrite  (host_RegWrite),
        .host_WriteReg  (host_WriteReg),
        .host_WriteData (host_WriteData),
        .host_ReadReg1  (host_ReadReg1),
        .host_ReadReg2  (host_ReadReg2),
        .rf             (rf)
    );

    always #5 clock = ~clock;

    logic [31:0] rf_mem  [32];
    logic [31:0] ref_mem [32];

    always_ff @(posedge clock) if (rf.RegWrite) rf_mem[rf.WriteReg] <= rf.WriteData;
    assign rf.ReadData1 = rf_mem[rf.ReadReg1];
    assign rf.ReadData2 = rf_mem[rf.ReadReg2];

    typedef struct {
        logic [71:0] acc;
        logic [31:0] wdata;
        logic        sat;
        int          dest;
        int          len;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0, wr_cnt = 0;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic signed [71:0] dot(input int a, input int b, input int l);
        logic signed [71:0] s = '0;
        for (int i = 0; i < l; i++) begin
            logic signed [63:0] p;
            p = $signed(ref_mem[(a + i) % 32]) * $signed(ref_mem[(b + i) % 32]);
            s = s + {{8{p[63]}}, p};
        end
        return s;
    endfunction

    function automatic logic [31:0] wb_model(input logic signed [71:0] a);
`ifdef MAC_SAT_EN
        if (a > 72'sd2147483647)  return 32'h7FFFFFFF;
        if (a < -72'sd2147483648) return 32'h80000000;
`endif
        return a[31:0];
    endfunction

    function automatic logic sat_model(input logic signed [71:0] a);
`ifdef MAC_SAT_EN
        return (a > 72'sd2147483647) || (a < -72'sd2147483648);
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clock) begin : mon
        exp_t e;
        if (rf.RegWrite && busy) wr_cnt++;
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", done, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.acc);
                if (e.len != 0) chk("wb_data", rf_mem[e.dest], e.wdata);
`ifdef MAC_SAT_EN
                chk("sat_flag", sat_flag, e.sat);
`endif
            end
        end
    end

    task automatic host_wr(input int r, input logic [31:0] v);
        host_RegWrite  = 1'b1;
        host_WriteReg  = 5'(r);
        host_WriteData = v;
        ref_mem[r]     = v;
        @(negedge clock);
        host_RegWrite  = 1'b0;
    endtask

    task automatic run_job(input int a, input int b, input int l, input int d, input bit poke);
        exp_t e;
        int   cyc, wr0;
        e.acc   = dot(a, b, l);
        e.wdata = wb_model(e.acc);
        e.sat   = sat_model(e.acc);
        e.dest  = d;
        e.len   = l;
        if (l != 0) ref_mem[d] = e.wdata;
        sb.push_back(e);
        wr0 = wr_cnt;
        base_a = 5'(a); base_b = 5'(b); len = 6'(l); dest_reg = 5'(d);
        start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
            start = poke && (cyc == 3);
            if (poke && cyc == 2) begin
                host_RegWrite = 1'b1; host_WriteReg = 5'd10; host_WriteData = 32'hDEADBEEF;
                #1 chk("host_stall", host_stall, 1'b1);
            end else begin
                host_RegWrite = 1'b0;
            end
        end while (!done && cyc < 100);
        host_RegWrite = 1'b0;
        start = 1'b0;
        chk("latency", cyc, (l == 0) ? 1 : l + 2);
        chk("wb_count", wr_cnt - wr0, (l != 0) ? 1 : 0);
        @(negedge clock);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, '0);
        chk("rst_stall", host_stall, 1'b0);
        chk("rst_regwrite", rf.RegWrite, 1'b0);
`ifdef MAC_SAT_EN
        chk("rst_sat", sat_flag, 1'b0);
`endif
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 32; i++) begin
            logic [31:0] v;
            v = 32'(i * 100003);
            if (i == 0)  v = 32'd903;
            if (i == 1)  v = 32'd7258;
            if (i == 16) v = 32'hFFFFEB45;
            if (i == 31) v = 32'd1651;
            host_wr(i, v);
        end
        host_ReadReg1 = 5'd16; host_ReadReg2 = 5'd31;
        #1;
        chk("pass_rd1", rf.ReadData1, ref_mem[16]);
        chk("pass_rr2", rf.ReadReg2, 5'd31);
        @(negedge clock);

        run_job(0, 0, 1, 31, 1'b0);
        chk("t1_result", result, 72'd815409);
        chk("t1_r31", rf_mem[31], 32'd815409);
        host_wr(31, 32'd1651);
        run_job(0, 0, 2, 3, 1'b0);
        chk("t2_result", result, 72'd53493973);
        run_job(31, 31, 2, 5, 1'b0);
        chk("t3_wrap", result, 72'd3541210);
        run_job(16, 0, 1, 6, 1'b0);
        chk("t4_signed", result, -72'sd4792221);
        chk("t4_wdata", rf_mem[6], 32'hFFB6E063);
        run_job(0, 0, 32, 7, 1'b0);
        run_job(0, 0, 0, 9, 1'b0);
        chk("t6_len0", result, '0);
        run_job(1, 2, 8, 20, 1'b1);
        chk("stall_drop", rf_mem[10], ref_mem[10]);

        base_a = 5'd4; base_b = 5'd5; len = 6'd10; dest_reg = 5'd12;
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_result", result, '0);
        chk("mid_rst_regwrite", rf.RegWrite, 1'b0);
        @(negedge clock); reset = 1'b0;
        repeat (15) @(negedge clock);
        chk("mid_rst_no_wb", rf_mem[12], ref_mem[12]);

        run_job(2, 3, 4, 13, 1'b0);
        repeat (3) @(negedge clock);
        chk("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
